// File: rtl/shift_normalizer.sv
// Sequential normalizer: shifts a word toward its MSB (lr=1) or LSB (lr=0) until that bit is set,
// reporting the shift count. Define FAST_NIBBLE_EN to skip four all-zero bits in a single cycle.
module shift_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lr_q, lr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] ocount_q, ocount_d;
  logic             zero_q, zero_d;
  logic             target_set;

  assign target_set = lr_q ? work_q[WIDTH-1] : work_q[0];

`ifdef FAST_NIBBLE_EN
  logic nibble_clear;
  assign nibble_clear = lr_q ? (work_q[WIDTH-1 -: 4] == 4'b0000) : (work_q[3:0] == 4'b0000);
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_count = ocount_q;
  assign out_zero  = zero_q;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    lr_d     = lr_q;
    data_d   = data_q;
    ocount_d = ocount_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_data;
          lr_d    = in_lr;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (work_q == '0) begin
          zero_d   = 1'b1;
          data_d   = '0;
          ocount_d = '0;
          state_d  = DONE;
        end else if (target_set) begin
          zero_d   = 1'b0;
          data_d   = work_q;
          ocount_d = count_q;
          state_d  = DONE;
        end
`ifdef FAST_NIBBLE_EN
        // A non-zero word with a clear nibble is always at least 4 positions from done,
        // so the count cannot overflow here.
        else if (nibble_clear) begin
          work_d  = lr_q ? (work_q << 4) : (work_q >> 4);
          count_d = count_q + CNT_W'(4);
        end
`endif
        else begin
          work_d  = lr_q ? (work_q << 1) : (work_q >> 1);
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= '0;
      lr_q     <= 1'b0;
      data_q   <= '0;
      ocount_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      lr_q     <= lr_d;
      data_q   <= data_d;
      ocount_q <= ocount_d;
      zero_q   <= zero_d;
    end
  end

endmodule
